// File: rtl/tcu_noc_burst_packer.sv
// Packs a TCU send command plus its 64-bit payload words into NoC flits:
// one flit for a single word, otherwise a header flit followed by two-word payload flits.
module tcu_noc_burst_packer #(
  parameter int NOC_DATA_SIZE   = 64,
  parameter int NOC_ADDR_SIZE   = 32,
  parameter int NOC_MODE_SIZE   = 4,
  parameter int NOC_MODID_SIZE  = 8,
  parameter int NOC_CHIPID_SIZE = 6,
  parameter int NOC_BSEL_SIZE   = 16,
  parameter int MAX_BURST_FLITS = 32,
  parameter int LEN_SIZE        = 7
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [LEN_SIZE-1:0]        cmd_len_i,
  input  logic [NOC_CHIPID_SIZE-1:0] cmd_trg_chipid_i,
  input  logic [NOC_MODID_SIZE-1:0]  cmd_trg_modid_i,
  input  logic [NOC_MODE_SIZE-1:0]   cmd_mode_i,
  input  logic [NOC_ADDR_SIZE-1:0]   cmd_addr_i,
  input  logic [NOC_CHIPID_SIZE-1:0] src_chipid_i,
  input  logic [NOC_MODID_SIZE-1:0]  src_modid_i,
  input  logic                       wdata_valid_i,
  input  logic [NOC_DATA_SIZE-1:0]   wdata_i,
  output logic                       wdata_ready_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic                       noc_wrreq_o,
  output logic                       noc_burst_o,
  output logic [NOC_BSEL_SIZE-1:0]   noc_bsel_o,
  output logic [NOC_CHIPID_SIZE-1:0] noc_src_chipid_o,
  output logic [NOC_MODID_SIZE-1:0]  noc_src_modid_o,
  output logic [NOC_CHIPID_SIZE-1:0] noc_trg_chipid_o,
  output logic [NOC_MODID_SIZE-1:0]  noc_trg_modid_o,
  output logic [NOC_MODE_SIZE-1:0]   noc_mode_o,
  output logic [NOC_ADDR_SIZE-1:0]   noc_addr_o,
  output logic [NOC_DATA_SIZE-1:0]   noc_data0_o,
  output logic [NOC_DATA_SIZE-1:0]   noc_data1_o,
  input  logic                       noc_stall_i
);

  localparam logic [LEN_SIZE:0] MAX_WORDS = (LEN_SIZE+1)'(2*MAX_BURST_FLITS);
  localparam logic [NOC_BSEL_SIZE-1:0] BSEL_LO =
    {{(NOC_BSEL_SIZE/2){1'b0}}, {(NOC_BSEL_SIZE/2){1'b1}}};

  typedef enum logic [1:0] {IDLE, HDR, PAY, LAST} state_t;

  typedef struct packed {
    logic                       burst;
    logic [NOC_BSEL_SIZE-1:0]   bsel;
    logic [NOC_CHIPID_SIZE-1:0] src_chipid;
    logic [NOC_MODID_SIZE-1:0]  src_modid;
    logic [NOC_CHIPID_SIZE-1:0] trg_chipid;
    logic [NOC_MODID_SIZE-1:0]  trg_modid;
    logic [NOC_MODE_SIZE-1:0]   mode;
    logic [NOC_ADDR_SIZE-1:0]   addr;
    logic [NOC_DATA_SIZE-1:0]   data0;
    logic [NOC_DATA_SIZE-1:0]   data1;
  } flit_t;

  typedef struct packed {
    logic [NOC_CHIPID_SIZE-1:0] trg_chipid;
    logic [NOC_MODID_SIZE-1:0]  trg_modid;
    logic [NOC_MODE_SIZE-1:0]   mode;
    logic [NOC_ADDR_SIZE-1:0]   addr;
  } cmd_t;

  state_t               state, state_nxt;
  flit_t                flit_q, flit_d;
  logic                 flit_load;
  logic                 wrreq_q;
  cmd_t                 cmd_q;
  logic [LEN_SIZE-1:0]  cnt;
  logic [LEN_SIZE-1:0]  cnt_dec;
  logic                 odd;
  logic                 single;
  logic [NOC_DATA_SIZE-1:0] lo_reg;
  logic                 err_q;

  logic out_free, cmd_acc, word_acc, len_bad, len_one;

  // Output register may take a new flit when empty or being drained this cycle.
  assign out_free = !wrreq_q || !noc_stall_i;
  assign cmd_acc  = cmd_valid_i && cmd_ready_o;
  assign word_acc = wdata_valid_i && wdata_ready_o;
  assign len_bad  = (cmd_len_i == '0) || ({1'b0, cmd_len_i} > MAX_WORDS);
  assign len_one  = (cmd_len_i == LEN_SIZE'(1));
  assign cnt_dec  = cnt - LEN_SIZE'(1);

  // FSM: state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_acc && !len_bad) state_nxt = len_one ? LAST : HDR;
      HDR:  state_nxt = PAY;
      PAY:  if (word_acc && odd) begin
              if (cnt_dec == '0)                 state_nxt = IDLE;
              else if (cnt_dec == LEN_SIZE'(1))  state_nxt = LAST;
            end
      LAST: if (word_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: handshake outputs; odd words and the final word need room in the output register
  always_comb begin
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    case (state)
      IDLE:    cmd_ready_o   = out_free;
      HDR:     wdata_ready_o = 1'b1;
      PAY:     wdata_ready_o = odd ? out_free : 1'b1;
      LAST:    wdata_ready_o = out_free;
      default: ;
    endcase
  end

  // Next flit: header on command accept, pair on odd word, tail on last word.
  always_comb begin
    flit_d    = '0;
    flit_load = 1'b0;
    if (state == IDLE && cmd_acc && !len_bad && !len_one) begin
      flit_load         = 1'b1;
      flit_d.burst      = 1'b1;
      flit_d.bsel       = '1;
      flit_d.src_chipid = src_chipid_i;
      flit_d.src_modid  = src_modid_i;
      flit_d.trg_chipid = cmd_trg_chipid_i;
      flit_d.trg_modid  = cmd_trg_modid_i;
      flit_d.mode       = cmd_mode_i;
      flit_d.addr       = cmd_addr_i;
      flit_d.data0      = NOC_DATA_SIZE'(cmd_len_i);
    end else if (state == PAY && odd && word_acc) begin
      flit_load    = 1'b1;
      flit_d.burst = (cnt_dec != '0);
      flit_d.bsel  = '1;
      flit_d.data0 = lo_reg;
      flit_d.data1 = wdata_i;
    end else if (state == LAST && word_acc) begin
      flit_load    = 1'b1;
      flit_d.bsel  = BSEL_LO;
      flit_d.data0 = wdata_i;
      if (single) begin
        flit_d.src_chipid = src_chipid_i;
        flit_d.src_modid  = src_modid_i;
        flit_d.trg_chipid = cmd_q.trg_chipid;
        flit_d.trg_modid  = cmd_q.trg_modid;
        flit_d.mode       = cmd_q.mode;
        flit_d.addr       = cmd_q.addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrreq_q <= 1'b0;
      flit_q  <= '0;
    end else if (flit_load) begin
      wrreq_q <= 1'b1;
      flit_q  <= flit_d;
    end else if (!noc_stall_i) begin
      wrreq_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_q  <= '0;
      cnt    <= '0;
      odd    <= 1'b0;
      single <= 1'b0;
      lo_reg <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= cmd_acc && len_bad;
      if (cmd_acc) begin
        cmd_q  <= '{cmd_trg_chipid_i, cmd_trg_modid_i, cmd_mode_i, cmd_addr_i};
        cnt    <= cmd_len_i;
        odd    <= 1'b0;
        single <= len_one;
      end else if (word_acc) begin
        cnt <= cnt_dec;
        odd <= !odd;
        if (!odd) lo_reg <= wdata_i;
      end
    end
  end

  assign err_o            = err_q;
  assign busy_o           = (state != IDLE) || wrreq_q;
  assign noc_wrreq_o      = wrreq_q;
  assign noc_burst_o      = flit_q.burst;
  assign noc_bsel_o       = flit_q.bsel;
  assign noc_src_chipid_o = flit_q.src_chipid;
  assign noc_src_modid_o  = flit_q.src_modid;
  assign noc_trg_chipid_o = flit_q.trg_chipid;
  assign noc_trg_modid_o  = flit_q.trg_modid;
  assign noc_mode_o       = flit_q.mode;
  assign noc_addr_o       = flit_q.addr;
  assign noc_data0_o      = flit_q.data0;
  assign noc_data1_o      = flit_q.data1;

endmodule

// File: tb/tb_tcu_noc_burst_packer.sv
// Bench for tcu_noc_burst_packer: directed plan steps plus randomized commands
// checked against a flit-list reference model.
module tb_tcu_noc_burst_packer;

  localparam logic [5:0] SRC_CHIP = 6'h2A;
  localparam logic [7:0] SRC_MOD  = 8'h5C;

  typedef struct packed {
    logic        burst;
    logic [15:0] bsel;
    logic [5:0]  src_chipid;
    logic [7:0]  src_modid;
    logic [5:0]  trg_chipid;
    logic [7:0]  trg_modid;
    logic [3:0]  mode;
    logic [31:0] addr;
    logic [63:0] data0;
    logic [63:0] data1;
  } tflit_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [6:0]  cmd_len_i = '0;
  logic [5:0]  cmd_trg_chipid_i = '0;
  logic [7:0]  cmd_trg_modid_i = '0;
  logic [3:0]  cmd_mode_i = '0;
  logic [31:0] cmd_addr_i = '0;
  logic        wdata_valid_i = 1'b0;
  logic [63:0] wdata_i = '0;
  logic        wdata_ready_o, err_o, busy_o, noc_wrreq_o, noc_burst_o;
  logic [15:0] noc_bsel_o;
  logic [5:0]  noc_src_chipid_o, noc_trg_chipid_o;
  logic [7:0]  noc_src_modid_o, noc_trg_modid_o;
  logic [3:0]  noc_mode_o;
  logic [31:0] noc_addr_o;
  logic [63:0] noc_data0_o, noc_data1_o;
  logic        noc_stall_i = 1'b0;

  tcu_noc_burst_packer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .cmd_trg_chipid_i(cmd_trg_chipid_i), .cmd_trg_modid_i(cmd_trg_modid_i),
    .cmd_mode_i(cmd_mode_i), .cmd_addr_i(cmd_addr_i),
    .src_chipid_i(SRC_CHIP), .src_modid_i(SRC_MOD),
    .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
    .err_o(err_o), .busy_o(busy_o),
    .noc_wrreq_o(noc_wrreq_o), .noc_burst_o(noc_burst_o), .noc_bsel_o(noc_bsel_o),
    .noc_src_chipid_o(noc_src_chipid_o), .noc_src_modid_o(noc_src_modid_o),
    .noc_trg_chipid_o(noc_trg_chipid_o), .noc_trg_modid_o(noc_trg_modid_o),
    .noc_mode_o(noc_mode_o), .noc_addr_o(noc_addr_o),
    .noc_data0_o(noc_data0_o), .noc_data1_o(noc_data1_o),
    .noc_stall_i(noc_stall_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int err_seen = 0;
  int stab_err = 0;
  tflit_t got_q[$];
  tflit_t exp_q[$];
  logic [63:0] words_q[$];

  function automatic tflit_t cur_flit();
    return '{noc_burst_o, noc_bsel_o, noc_src_chipid_o, noc_src_modid_o, noc_trg_chipid_o,
             noc_trg_modid_o, noc_mode_o, noc_addr_o, noc_data0_o, noc_data1_o};
  endfunction

  // Consumed flits, err pulses and any change of a stalled flit.
  tflit_t prev_f;
  bit     prev_stalled = 1'b0;
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      prev_stalled <= 1'b0;
    end else begin
      if (prev_stalled && (!noc_wrreq_o || cur_flit() !== prev_f)) stab_err <= stab_err + 1;
      if (noc_wrreq_o && !noc_stall_i) got_q.push_back(cur_flit());
      if (err_o) err_seen <= err_seen + 1;
      prev_stalled <= noc_wrreq_o && noc_stall_i;
      prev_f <= cur_flit();
    end
  end

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic tflit_t mkf(input logic b, input logic [15:0] bs, input logic ids,
                                 input logic [63:0] d0, input logic [63:0] d1);
    tflit_t f;
    f = '0;
    f.burst = b; f.bsel = bs; f.data0 = d0; f.data1 = d1;
    if (ids) begin
      f.src_chipid = SRC_CHIP;         f.src_modid = SRC_MOD;
      f.trg_chipid = cmd_trg_chipid_i; f.trg_modid = cmd_trg_modid_i;
      f.mode = cmd_mode_i;             f.addr = cmd_addr_i;
    end
    return f;
  endfunction

  // Reference: expected flit list for a command of len words in words_q.
  task automatic model(input int len);
    exp_q.delete();
    if (len < 1 || len > 64) return;
    if (len == 1) begin
      exp_q.push_back(mkf(1'b0, 16'h00FF, 1'b1, words_q[0], 64'h0));
      return;
    end
    exp_q.push_back(mkf(1'b1, 16'hFFFF, 1'b1, 64'(len), 64'h0));
    for (int i = 0; i < len; i += 2) begin
      if (i + 1 < len) exp_q.push_back(mkf(i + 2 < len, 16'hFFFF, 1'b0, words_q[i], words_q[i+1]));
      else             exp_q.push_back(mkf(1'b0, 16'h00FF, 1'b0, words_q[i], 64'h0));
    end
  endtask

  task automatic check_flits(input string tag);
    chki({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      assert (got_q[i] === exp_q[i]) else begin
        miscompares++;
        $error("FAIL %s.flit%0d: observed %h expected %h", tag, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic set_cmd(input int len, input logic [63:0] base);
    words_q.delete();
    for (int i = 0; i < len; i++)
      words_q.push_back(base != 0 ? base + 64'(i) : {$urandom, $urandom});
    cmd_len_i        = len[6:0];
    cmd_trg_chipid_i = 6'($urandom);
    cmd_trg_modid_i  = 8'($urandom);
    cmd_mode_i       = 4'($urandom);
    cmd_addr_i       = $urandom;
    model(len);
    got_q.delete();
  endtask

  // Full command with random word gaps and NoC stalls; base=0 means random words.
  task automatic run_cmd(input string tag, input int len, input logic [63:0] base,
                         input int stall_pct, input int gap_pct);
    int  sent, cyc, err0, stab0, nw;
    bit  acc, lat_chk;
    set_cmd(len, base);
    nw = (len >= 1 && len <= 64) ? len : 0;
    err0 = err_seen; stab0 = stab_err;
    acc = 0; sent = 0; cyc = 0; lat_chk = 0;
    cmd_valid_i = 1'b1;
    while (!(acc && sent == nw && !busy_o) && cyc < 3000) begin
      wdata_valid_i = acc && sent < nw && ($urandom_range(99) >= gap_pct);
      wdata_i       = sent < nw ? words_q[sent] : 64'h0;
      noc_stall_i   = $urandom_range(99) < stall_pct;
      @(negedge clk_i);
      if (lat_chk) begin
        chkb({tag, ".latency"}, noc_wrreq_o, 1'b1);
        lat_chk = 0;
      end
      if (cmd_valid_i && cmd_ready_o) acc = 1;
      if (wdata_valid_i && wdata_ready_o) begin
        sent++;
        if (sent == nw) lat_chk = 1;
      end
      @(posedge clk_i); #1;
      if (acc) cmd_valid_i = 1'b0;
      cyc++;
    end
    cmd_valid_i = 1'b0; wdata_valid_i = 1'b0; noc_stall_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chkb({tag, ".done_in_time"}, cyc < 3000, 1'b1);
    chki({tag, ".err_pulses"}, err_seen - err0, nw == 0 ? 1 : 0);
    chki({tag, ".stall_stable"}, stab_err - stab0, 0);
    chkb({tag, ".idle_busy"}, busy_o, 1'b0);
    check_flits(tag);
  endtask

  initial begin
    int len, i, cyc;
    // reset
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    @(negedge clk_i);
    chkb("rst.wrreq", noc_wrreq_o, 1'b0);
    chkb("rst.burst", noc_burst_o, 1'b0);
    chkw("rst.data0", noc_data0_o, 64'h0);
    chkw("rst.addr", 64'(noc_addr_o), 64'h0);
    chkw("rst.bsel", 64'(noc_bsel_o), 64'h0);
    chkb("rst.cmd_ready", cmd_ready_o, 1'b1);
    chkb("rst.wdata_ready", wdata_ready_o, 1'b0);
    chkb("rst.err", err_o, 1'b0);
    chkb("rst.busy", busy_o, 1'b0);
    @(posedge clk_i); #1;

    run_cmd("len1", 1, 64'hA5, 0, 0);
    run_cmd("len3", 3, 64'h1, 0, 0);

    // len=4, no stall, cycle-exact
    set_cmd(4, 64'h1);
    cmd_valid_i = 1'b1; wdata_valid_i = 1'b1; wdata_i = 64'd1;
    @(negedge clk_i); chkb("l4.c0_cmd_ready", cmd_ready_o, 1'b1);
    @(posedge clk_i); #1 cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chkb("l4.c1_hdr_wrreq", noc_wrreq_o, 1'b1);
    chkb("l4.c1_hdr_burst", noc_burst_o, 1'b1);
    chkw("l4.c1_hdr_data0", noc_data0_o, 64'd4);
    chkb("l4.c1_wdata_ready", wdata_ready_o, 1'b1);
    @(posedge clk_i); #1 wdata_i = 64'd2;
    @(negedge clk_i);
    chkb("l4.c2_wrreq", noc_wrreq_o, 1'b0);
    chkb("l4.c2_wdata_ready", wdata_ready_o, 1'b1);
    @(posedge clk_i); #1 wdata_i = 64'd3;
    @(negedge clk_i);
    chkw("l4.c3_data0", noc_data0_o, 64'd1);
    chkw("l4.c3_data1", noc_data1_o, 64'd2);
    chkb("l4.c3_burst", noc_burst_o, 1'b1);
    @(posedge clk_i); #1 wdata_i = 64'd4;
    @(posedge clk_i); #1 wdata_valid_i = 1'b0;
    @(negedge clk_i);
    chkw("l4.c5_data0", noc_data0_o, 64'd3);
    chkw("l4.c5_data1", noc_data1_o, 64'd4);
    chkb("l4.c5_burst", noc_burst_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 check_flits("l4");

    // len=4 with the header stalled for 5 cycles
    set_cmd(4, 64'h1);
    i = stab_err;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; noc_stall_i = 1'b1; wdata_valid_i = 1'b1; wdata_i = 64'd1;
    @(negedge clk_i);
    chkb("st.c1_wrreq", noc_wrreq_o, 1'b1);
    chkw("st.c1_data0", noc_data0_o, 64'd4);
    @(posedge clk_i); #1 wdata_i = 64'd2;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk_i);
      chkb($sformatf("st.c%0d_no_odd_accept", k), wdata_ready_o, 1'b0);
      chkw($sformatf("st.c%0d_hdr_held", k), noc_data0_o, 64'd4);
      @(posedge clk_i); #1;
    end
    noc_stall_i = 1'b0;
    @(negedge clk_i); chkb("st.c6_wdata_ready", wdata_ready_o, 1'b1);
    @(posedge clk_i); #1 wdata_i = 64'd3;
    @(posedge clk_i); #1 wdata_i = 64'd4;
    @(posedge clk_i); #1 wdata_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chki("st.stable", stab_err - i, 0);
    check_flits("st");

    run_cmd("len0", 0, 64'h0, 0, 0);
    run_cmd("len65", 65, 64'h0, 0, 0);

    // reset while the second payload flit of a len=8 burst is on the bus
    set_cmd(8, 64'h100);
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1 cmd_valid_i = 1'b0;
    i = 0; cyc = 0;
    while (got_q.size() < 3 && cyc < 100) begin
      wdata_valid_i = 1'b1; wdata_i = 64'h100 + 64'(i);
      @(negedge clk_i); #1;
      if (wdata_ready_o) i++;
      if (got_q.size() < 3) begin @(posedge clk_i); #1; end
      cyc++;
    end
    chkb("mid.reached", cyc < 100, 1'b1);
    wdata_valid_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chkb("mid.wrreq", noc_wrreq_o, 1'b0);
    chkw("mid.data0", noc_data0_o, 64'h0);
    chkb("mid.busy", busy_o, 1'b0);
    chkb("mid.wdata_ready", wdata_ready_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    got_q.delete();
    repeat (4) @(posedge clk_i);
    #1;
    chki("mid.no_flits", got_q.size(), 0);
    run_cmd("mid.len1", 1, 64'h0, 0, 0);

    // randomized commands, legal and illegal, with stalls and gaps
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(99);
      if (r < 8)       len = (r < 3) ? 0 : $urandom_range(127, 65);
      else if (r < 20) len = $urandom_range(3, 1);
      else             len = $urandom_range(64, 1);
      run_cmd($sformatf("rnd%0d.len%0d", n, len), len, 64'h0,
              $urandom_range(50), $urandom_range(40));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
